// File: rtl/quadrature_feedback.sv
// Quadrature encoder decoder: synchronizes and glitch-filters A/B, tracks a 32-bit
// position, and emits a periodic strobe with a consistent position/velocity sample.
module quadrature_feedback #(
    parameter int unsigned UPDATE_DIVIDER = 50000,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               zero_position,
    output logic signed [31:0] position,
    output logic signed [15:0] velocity,
    output logic               update_controller,
    output logic [7:0]         error_count
);

    localparam int unsigned    PW          = $clog2(UPDATE_DIVIDER);
    localparam logic [PW-1:0]  PERIOD_LAST = PW'(UPDATE_DIVIDER - 1);
    localparam logic [3:0]     FILT_LAST   = 4'(FILTER_LEN - 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t             state;
    logic [1:0]         sync1, sync2;   // bit 1 = A, bit 0 = B
    logic [1:0]         filt;
    logic [3:0]         fcnt [2];
    logic [3:0]         stable_cnt;
    logic [1:0]         prev;
    logic [PW-1:0]      period_cnt;
    logic signed [31:0] count, count_step, snapshot, delta;
    logic signed [15:0] vel_sat;
    logic [1:0]         diff;
    logic               step_up, step_dn, illegal;

    // Maps the Gray sequence 00,10,11,01 onto 0..3 so direction is a modulo-4 difference.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Synchronizer flops carry no reset so the filter sees the true pin level right after reset.
    always_ff @(posedge clock) begin
        sync1 <= {enc_a, enc_b};
        sync2 <= sync1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            filt <= '0;
            for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        diff       = gray_idx(filt) - gray_idx(prev);
        step_up    = (state == RUN) && (diff == 2'd1);
        step_dn    = (state == RUN) && (diff == 2'd3);
        illegal    = (state == RUN) && (diff == 2'd2);
        count_step = count;
        if (step_up)      count_step = count + 32'sd1;
        else if (step_dn) count_step = count - 32'sd1;
        delta = count_step - snapshot;
        if (delta > 32'sd32767)       vel_sat = 16'sh7FFF;
        else if (delta < -32'sd32768) vel_sat = 16'sh8000;
        else                          vel_sat = delta[15:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= PRIME;
            stable_cnt        <= '0;
            prev              <= '0;
            count             <= '0;
            snapshot          <= '0;
            period_cnt        <= '0;
            position          <= '0;
            velocity          <= '0;
            update_controller <= 1'b0;
            error_count       <= '0;
        end else begin
            update_controller <= 1'b0;

            case (state)
                PRIME: begin
                    // Reference is loaded only after both channels have settled, so no step is counted.
                    if (sync2 != filt) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == FILT_LAST) begin
                        stable_cnt <= '0;
                        prev       <= filt;
                        state      <= RUN;
                    end else begin
                        stable_cnt <= stable_cnt + 4'd1;
                    end
                end
                RUN: begin
                    prev <= filt;
                    if (illegal && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
                end
                default: state <= PRIME;
            endcase

            count <= zero_position ? '0 : count_step;

            if (period_cnt == PERIOD_LAST) begin
                period_cnt        <= '0;
                position          <= count_step;
                velocity          <= vel_sat;
                update_controller <= 1'b1;
                snapshot          <= zero_position ? '0 : count_step;
            end else begin
                period_cnt <= period_cnt + 1'b1;
                if (zero_position) snapshot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_feedback.sv
// Scoreboard bench for quadrature_feedback: stimulus threads push expected strobe
// samples, per-instance monitors pop and compare whenever update_controller is high.
module tb_quadrature_feedback;

    localparam int MAIN_DIV  = 1000;
    localparam int MAIN_FLT  = 3;
    localparam int SAT_DIV   = 66000;
    localparam int SAT_FLT   = 1;
    localparam int SAT_STEPS = 32770;

    typedef struct {
        int pos;
        int vel;
        int err;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               rst_v [3];
    logic               a_v   [3];
    logic               b_v   [3];
    logic               z_v   [3];
    logic signed [31:0] pos_v [3];
    logic signed [15:0] vel_v [3];
    logic               upd_v [3];
    logic [7:0]         err_v [3];
    logic [1:0]         ab    [3];

    exp_t q [3][$];
    int checks   = 0;
    int failures = 0;

    quadrature_feedback #(.UPDATE_DIVIDER(MAIN_DIV), .FILTER_LEN(MAIN_FLT)) u_main (
        .clock(clock), .reset_n(rst_v[0]), .enc_a(a_v[0]), .enc_b(b_v[0]),
        .zero_position(z_v[0]), .position(pos_v[0]), .velocity(vel_v[0]),
        .update_controller(upd_v[0]), .error_count(err_v[0])
    );

    quadrature_feedback #(.UPDATE_DIVIDER(SAT_DIV), .FILTER_LEN(SAT_FLT)) u_sat_pos (
        .clock(clock), .reset_n(rst_v[1]), .enc_a(a_v[1]), .enc_b(b_v[1]),
        .zero_position(z_v[1]), .position(pos_v[1]), .velocity(vel_v[1]),
        .update_controller(upd_v[1]), .error_count(err_v[1])
    );

    quadrature_feedback #(.UPDATE_DIVIDER(SAT_DIV), .FILTER_LEN(SAT_FLT)) u_sat_neg (
        .clock(clock), .reset_n(rst_v[2]), .enc_a(a_v[2]), .enc_b(b_v[2]),
        .zero_position(z_v[2]), .position(pos_v[2]), .velocity(vel_v[2]),
        .update_controller(upd_v[2]), .error_count(err_v[2])
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push(input int id, input int pos, input int vel, input int err);
        exp_t e;
        e.pos = pos;
        e.vel = vel;
        e.err = err;
        q[id].push_back(e);
    endtask

    task automatic set_ab(input int id, input logic [1:0] v, input int gap);
        ab[id]  = v;
        a_v[id] = v[1];
        b_v[id] = v[0];
        repeat (gap) @(negedge clock);
    endtask

    task automatic step(input int id, input bit fwd, input int gap);
        set_ab(id, fwd ? fwd_of(ab[id]) : rev_of(ab[id]), gap);
    endtask

    task automatic wait_strobe(input int id, input int limit, input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (upd_v[id]) break;
            if (n >= limit) begin
                checks++;
                failures++;
                $display("FAIL %s_strobe_timeout actual=none required=strobe_within_%0d", tag, limit);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input int id, input string tag);
        check({tag, "_pos"}, pos_v[id], 0);
        check({tag, "_vel"}, vel_v[id], 0);
        check({tag, "_upd"}, int'(upd_v[id]), 0);
        check({tag, "_err"}, int'(err_v[id]), 0);
    endtask

    task automatic mon(input int id, input int div, input string tag);
        int   cyc;
        exp_t e;
        cyc = -1;
        forever begin
            @(negedge clock);
            #1;
            if (!rst_v[id]) begin
                cyc = -1;
            end else begin
                cyc++;
                if (upd_v[id]) begin
                    check({tag, "_period"}, cyc, div);
                    cyc = 0;
                    if (q[id].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s_unexpected_strobe actual=strobe required=none", tag);
                    end else begin
                        e = q[id].pop_front();
                        check({tag, "_position"}, pos_v[id], e.pos);
                        check({tag, "_velocity"}, vel_v[id], e.vel);
                        check({tag, "_error_count"}, int'(err_v[id]), e.err);
                    end
                end
            end
        end
    endtask

    initial mon(0, MAIN_DIV, "main");
    initial mon(1, SAT_DIV, "satpos");
    initial mon(2, SAT_DIV, "satneg");

    task automatic main_seq();
        rst_v[0] = 1'b0;
        z_v[0]   = 1'b0;
        set_ab(0, 2'b00, 5);
        check_reset_outputs(0, "main_reset");
        rst_v[0] = 1'b1;

        // forward count
        push(0, 40, 40, 0);
        repeat (20) @(negedge clock);
        for (int i = 0; i < 40; i++) step(0, 1'b1, 8);
        wait_strobe(0, 1500, "fwd");
        push(0, 40, 0, 0);
        wait_strobe(0, 1500, "idle");

        // clear, then reverse count
        push(0, -5, -5, 0);
        z_v[0] = 1'b1;
        @(negedge clock);
        z_v[0] = 1'b0;
        repeat (19) @(negedge clock);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8);
        wait_strobe(0, 1500, "rev");

        // two-cycle glitch on B is rejected
        push(0, -5, 0, 0);
        b_v[0] = ~ab[0][0];
        repeat (2) @(negedge clock);
        b_v[0] = ab[0][0];
        wait_strobe(0, 1500, "glitch");

        // persistent change on B (01 -> 00) is one forward step
        push(0, -4, 1, 0);
        step(0, 1'b1, 8);
        wait_strobe(0, 1500, "held");

        // illegal transitions
        push(0, -4, 0, 1);
        set_ab(0, 2'b11, 8);
        wait_strobe(0, 1500, "illegal1");
        push(0, -4, 0, 151);
        for (int i = 0; i < 150; i++) set_ab(0, ~ab[0], 5);
        wait_strobe(0, 1500, "illegal151");
        push(0, -4, 0, 255);
        for (int i = 0; i < 150; i++) set_ab(0, ~ab[0], 5);
        wait_strobe(0, 1500, "illegal_sat");

        // reset mid-operation with encoder held at 11
        @(negedge clock);
        rst_v[0] = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs(0, "main_midreset");
        repeat (3) @(negedge clock);
        rst_v[0] = 1'b1;
        push(0, 0, 0, 0);
        wait_strobe(0, 1500, "prime11");

        // three steps, then clear coinciding with the fourth step's count edge
        push(0, 0, 0, 0);
        repeat (20) @(negedge clock);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 8);
        step(0, 1'b1, 5);
        z_v[0] = 1'b1;
        @(negedge clock);
        z_v[0] = 1'b0;
        wait_strobe(0, 1500, "zero_step");

        push(0, 1, 1, 0);
        step(0, 1'b1, 8);
        wait_strobe(0, 1500, "after_zero");

        // clear on the strobe edge: sample keeps pre-clear value
        push(0, 3, 2, 0);
        step(0, 1'b1, 8);
        step(0, 1'b1, 8);
        repeat (MAIN_DIV - 1 - 16) @(negedge clock);
        z_v[0] = 1'b1;
        wait_strobe(0, 1500, "zero_strobe");
        z_v[0] = 1'b0;
        push(0, 0, 0, 0);
        wait_strobe(0, 1500, "post_zero_strobe");

        @(negedge clock);
        rst_v[0] = 1'b0;
    endtask

    task automatic sat_seq();
        rst_v[1] = 1'b0;
        rst_v[2] = 1'b0;
        z_v[1]   = 1'b0;
        z_v[2]   = 1'b0;
        set_ab(1, 2'b00, 0);
        set_ab(2, 2'b00, 5);
        rst_v[1] = 1'b1;
        rst_v[2] = 1'b1;
        push(1, SAT_STEPS, 32767, 0);
        push(2, -SAT_STEPS, -32768, 0);
        repeat (10) @(negedge clock);
        for (int i = 0; i < SAT_STEPS; i++) begin
            step(1, 1'b1, 0);
            step(2, 1'b0, 2);
        end
        wait_strobe(1, SAT_DIV + 100, "sat");
        @(negedge clock);
        rst_v[1] = 1'b0;
        rst_v[2] = 1'b0;
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        repeat (5) @(negedge clock);
        check("main_queue_drained", q[0].size(), 0);
        check("satpos_queue_drained", q[1].size(), 0);
        check("satneg_queue_drained", q[2].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
